// File: rtl/pps_pkg.sv
// Shared definitions for the PPS period filter: lock-state encoding,
// consecutive-bad limit and the saturating statistics increment.
package pps_pkg;

    typedef enum logic [0:0] {
        PPS_HUNT   = 1'b0,
        PPS_LOCKED = 1'b1
    } pps_state_e;

    // Bad samples in a row that drop LOCKED back to HUNT
    localparam int unsigned PPS_BAD_LIMIT = 2;

    function automatic logic [15:0] pps_sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'h0001;
    endfunction

endpackage

// File: rtl/axis_pps_window_check.sv
// First pipeline stage: registers each period sample together with the
// result of the |sample - nominal| <= tolerance window test.
module axis_pps_window_check #(
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNTR_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    input  logic [CNTR_WIDTH-1:0] cfg_nominal,
    input  logic [CNTR_WIDTH-1:0] cfg_tolerance,
    output logic                  chk_valid,
    output logic                  chk_good,
    output logic [CNTR_WIDTH-1:0] chk_data
);

    logic [CNTR_WIDTH:0] data_ext_s;
    logic [CNTR_WIDTH:0] nom_ext_s;
    logic [CNTR_WIDTH:0] diff_s;
    logic                good_s;
    logic                valid_r;
    logic                good_r;
    logic [CNTR_WIDTH-1:0] data_r;

    // Absolute deviation with one guard bit so neither operand order wraps
    always_comb begin
        data_ext_s = {1'b0, sample_data};
        nom_ext_s  = {1'b0, cfg_nominal};
        if (data_ext_s >= nom_ext_s) begin
            diff_s = data_ext_s - nom_ext_s;
        end else begin
            diff_s = nom_ext_s - data_ext_s;
        end
        good_s = (diff_s <= {1'b0, cfg_tolerance});
    end

    // Stage-1 sample register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_r <= 1'b0;
            good_r  <= 1'b0;
            data_r  <= {CNTR_WIDTH{1'b0}};
        end else begin
            valid_r <= sample_valid;
            if (sample_valid) begin
                good_r <= good_s;
                data_r <= sample_data;
            end
        end
    end

    assign chk_valid = valid_r;
    assign chk_good  = good_r;
    assign chk_data  = data_r;

endmodule

// File: rtl/axis_pps_filter.sv
// PPS period filter: window-checks period samples, sums blocks of
// 2^AVG_LOG2 good periods and tracks HUNT/LOCKED with a watchdog.
// Optional reject statistics are enabled with PPS_FILTER_STATS_EN.
module axis_pps_filter
    import pps_pkg::*;
#(
    parameter int CNTR_WIDTH         = 32,
    parameter int AVG_LOG2           = 3,
    parameter int M_AXIS_TDATA_WIDTH = 64
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [CNTR_WIDTH-1:0]         cfg_nominal,
    input  logic [CNTR_WIDTH-1:0]         cfg_tolerance,
    input  logic [CNTR_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          sts_locked,
    output logic                          sts_overrun,
    output logic [15:0]                   sts_reject_cnt
);

    localparam int ACC_W = CNTR_WIDTH + AVG_LOG2;
    localparam int BLK_W = AVG_LOG2 + 1;
    localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'((2 ** AVG_LOG2) - 1);
    localparam logic [BLK_W-1:0]      BLK_ONE  = {{(BLK_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]            BAD_LAST = 2'(PPS_BAD_LIMIT - 1);
    localparam logic [CNTR_WIDTH:0]   WD_ONE   = {{CNTR_WIDTH{1'b0}}, 1'b1};

    logic                  chk_valid_s;
    logic                  chk_good_s;
    logic [CNTR_WIDTH-1:0] chk_data_s;

    pps_state_e            state_r, state_nxt_s;
    logic [ACC_W-1:0]      acc_r, acc_nxt_s, sum_s;
    logic [BLK_W-1:0]      blk_r, blk_nxt_s;
    logic [1:0]            bad_r, bad_nxt_s;
    logic                  complete_s;

    logic [CNTR_WIDTH:0]   wd_cnt_r;
    logic [CNTR_WIDTH:0]   wd_inc_s;
    logic [CNTR_WIDTH:0]   limit_s;
    logic                  wd_armed_r;
    logic                  timeout_s;

    logic [M_AXIS_TDATA_WIDTH-1:0] tdata_r;
    logic                          tvalid_r;
    logic                          overrun_r;
    logic                          locked_r;

    axis_pps_window_check #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_window_check (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .sample_data   (s_axis_tdata),
        .sample_valid  (s_axis_tvalid),
        .cfg_nominal   (cfg_nominal),
        .cfg_tolerance (cfg_tolerance),
        .chk_valid     (chk_valid_s),
        .chk_good      (chk_good_s),
        .chk_data      (chk_data_s)
    );

    // A sample on the expiry cycle suppresses the timeout
    assign limit_s   = {1'b0, cfg_nominal} + {1'b0, cfg_tolerance};
    assign wd_inc_s  = wd_cnt_r + WD_ONE;
    assign timeout_s = wd_armed_r & ~s_axis_tvalid & (wd_inc_s > limit_s);

    // Next-state, block accumulation and lock decisions
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        blk_nxt_s   = blk_r;
        bad_nxt_s   = bad_r;
        complete_s  = 1'b0;
        sum_s       = acc_r + ACC_W'(chk_data_s);
        if (timeout_s) begin
            state_nxt_s = PPS_HUNT;
            acc_nxt_s   = {ACC_W{1'b0}};
            blk_nxt_s   = {BLK_W{1'b0}};
            bad_nxt_s   = 2'd0;
        end else if (chk_valid_s) begin
            if (chk_good_s) begin
                bad_nxt_s = 2'd0;
                if (blk_r == BLK_LAST) begin
                    complete_s  = 1'b1;
                    acc_nxt_s   = {ACC_W{1'b0}};
                    blk_nxt_s   = {BLK_W{1'b0}};
                    state_nxt_s = PPS_LOCKED;
                end else begin
                    acc_nxt_s = sum_s;
                    blk_nxt_s = blk_r + BLK_ONE;
                end
            end else begin
                case (state_r)
                    PPS_HUNT: begin
                        acc_nxt_s = {ACC_W{1'b0}};
                        blk_nxt_s = {BLK_W{1'b0}};
                        bad_nxt_s = 2'd0;
                    end
                    PPS_LOCKED: begin
                        if (bad_r == BAD_LAST) begin
                            state_nxt_s = PPS_HUNT;
                            acc_nxt_s   = {ACC_W{1'b0}};
                            blk_nxt_s   = {BLK_W{1'b0}};
                            bad_nxt_s   = 2'd0;
                        end else begin
                            bad_nxt_s = bad_r + 2'd1;
                        end
                    end
                    default: begin
                        state_nxt_s = PPS_HUNT;
                        acc_nxt_s   = {ACC_W{1'b0}};
                        blk_nxt_s   = {BLK_W{1'b0}};
                        bad_nxt_s   = 2'd0;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Lock state, accumulator and block counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= PPS_HUNT;
            acc_r    <= {ACC_W{1'b0}};
            blk_r    <= {BLK_W{1'b0}};
            bad_r    <= 2'd0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            acc_r    <= acc_nxt_s;
            blk_r    <= blk_nxt_s;
            bad_r    <= bad_nxt_s;
            locked_r <= (state_nxt_s == PPS_LOCKED);
        end
    end

    // Watchdog: cycles since the last input strobe
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt_r   <= {(CNTR_WIDTH+1){1'b0}};
            wd_armed_r <= 1'b0;
        end else if (s_axis_tvalid) begin
            wd_cnt_r   <= {(CNTR_WIDTH+1){1'b0}};
            wd_armed_r <= 1'b1;
        end else if (timeout_s) begin
            wd_cnt_r   <= {(CNTR_WIDTH+1){1'b0}};
            wd_armed_r <= 1'b0;
        end else if (wd_armed_r) begin
            wd_cnt_r <= wd_inc_s;
        end
    end

    // Output register; a completion while stalled overwrites and flags overrun
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_r   <= {M_AXIS_TDATA_WIDTH{1'b0}};
            tvalid_r  <= 1'b0;
            overrun_r <= 1'b0;
        end else if (complete_s) begin
            tdata_r  <= M_AXIS_TDATA_WIDTH'(sum_s);
            tvalid_r <= 1'b1;
            if (tvalid_r && !m_axis_tready) begin
                overrun_r <= 1'b1;
            end
        end else if (tvalid_r && m_axis_tready) begin
            tvalid_r <= 1'b0;
        end
    end

`ifdef PPS_FILTER_STATS_EN
    logic [15:0] reject_cnt_r;
    logic        reject_s;

    assign reject_s = chk_valid_s & ~chk_good_s;

    // Saturating count of rejected samples
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reject_cnt_r <= 16'h0000;
        end else if (reject_s) begin
            reject_cnt_r <= pps_sat_inc16(reject_cnt_r);
        end
    end

    assign sts_reject_cnt = reject_cnt_r;
`else
    assign sts_reject_cnt = 16'h0000;
`endif

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign sts_overrun   = overrun_r;
    assign sts_locked    = locked_r;

endmodule

// File: tb/tb_axis_pps_filter.sv
// Directed-plus-random bench for axis_pps_filter against a sample-level
// reference model (block queue, lock flag, bad-run count, watchdog deadline).
module tb_axis_pps_filter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_nominal;
    logic [31:0] cfg_tolerance;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        sts_locked;
    logic        sts_overrun;
    logic [15:0] sts_reject_cnt;

`ifdef PPS_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    axis_pps_filter #(
        .CNTR_WIDTH         (32),
        .AVG_LOG2           (3),
        .M_AXIS_TDATA_WIDTH (64)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_nominal    (cfg_nominal),
        .cfg_tolerance  (cfg_tolerance),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .sts_locked     (sts_locked),
        .sts_overrun    (sts_overrun),
        .sts_reject_cnt (sts_reject_cnt)
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] blk_q[$];
    bit          m_locked;
    int          m_bad_run;
    bit          m_armed;
    int unsigned m_last;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_ovr;
    logic [15:0] exp_rej;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        blk_q.delete();
        m_locked  = 1'b0;
        m_bad_run = 0;
        m_armed   = 1'b0;
        m_last    = 0;
        exp_valid = 1'b0;
        exp_data  = 64'd0;
        exp_ovr   = 1'b0;
        exp_rej   = 16'd0;
    endtask

    // A period gap longer than nominal+tolerance empty cycles drops the lock
    task automatic apply_timeout(input int unsigned now);
        logic [63:0] lim;
        lim = {32'd0, cfg_nominal} + {32'd0, cfg_tolerance};
        if (m_armed && ({32'd0, now} >= {32'd0, m_last} + lim + 64'd2)) begin
            m_locked  = 1'b0;
            m_bad_run = 0;
            m_armed   = 1'b0;
            blk_q.delete();
        end
    endtask

    task automatic model_sample(input logic [31:0] d, input int unsigned c);
        logic [63:0] dd, nn, diff, sum;
        apply_timeout(c);
        m_armed = 1'b1;
        m_last  = c;
        dd   = {32'd0, d};
        nn   = {32'd0, cfg_nominal};
        diff = (dd >= nn) ? dd - nn : nn - dd;
        if (diff <= {32'd0, cfg_tolerance}) begin
            m_bad_run = 0;
            blk_q.push_back(d);
            if (blk_q.size() == 8) begin
                sum = 64'd0;
                foreach (blk_q[i]) sum += {32'd0, blk_q[i]};
                if (exp_valid && !m_axis_tready) exp_ovr = 1'b1;
                exp_valid = 1'b1;
                exp_data  = sum;
                blk_q.delete();
                m_locked = 1'b1;
            end
        end else begin
            if (STATS && exp_rej != 16'hFFFF) exp_rej = exp_rej + 16'd1;
            if (m_locked) begin
                m_bad_run++;
                if (m_bad_run >= 2) begin
                    m_locked  = 1'b0;
                    m_bad_run = 0;
                    blk_q.delete();
                end
            end else begin
                m_bad_run = 0;
                blk_q.delete();
            end
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_all(input string tag);
        apply_timeout(cyc);
        chk({tag, " tvalid"},  {63'd0, m_axis_tvalid}, {63'd0, exp_valid});
        chk({tag, " tdata"},   m_axis_tdata, exp_data);
        chk({tag, " locked"},  {63'd0, sts_locked}, {63'd0, m_locked});
        chk({tag, " overrun"}, {63'd0, sts_overrun}, {63'd0, exp_ovr});
        chk({tag, " rejects"}, {48'd0, sts_reject_cnt}, {48'd0, exp_rej});
    endtask

    // Drive one strobe; returns one cycle after the sample cycle
    task automatic send(input logic [31:0] d);
        step();
        model_sample(d, cyc);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_check(input logic [31:0] d, input string tag);
        send(d);
        step();
        check_all(tag);
        if (m_axis_tready && exp_valid) begin
            step();
            exp_valid = 1'b0;
            chk({tag, " pulse end"}, {63'd0, m_axis_tvalid}, 64'd0);
        end
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) step();
    endtask

    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        #2;
        chk({tag, " rst tvalid"},  {63'd0, m_axis_tvalid}, 64'd0);
        chk({tag, " rst tdata"},   m_axis_tdata, 64'd0);
        chk({tag, " rst locked"},  {63'd0, sts_locked}, 64'd0);
        chk({tag, " rst overrun"}, {63'd0, sts_overrun}, 64'd0);
        chk({tag, " rst rejects"}, {48'd0, sts_reject_cnt}, 64'd0);
        chk({tag, " rst tready"},  {63'd0, s_axis_tready}, 64'd1);
        model_reset();
        step();
        aresetn = 1'b1;
        step();
    endtask

    function automatic logic [31:0] rnd_good();
        return cfg_nominal - cfg_tolerance + 32'($urandom_range(0, 2 * cfg_tolerance));
    endfunction

    function automatic logic [31:0] rnd_bad();
        if ($urandom_range(0, 1) == 1)
            return cfg_nominal + cfg_tolerance + 32'd1 + 32'($urandom_range(0, 100000));
        else
            return cfg_nominal - cfg_tolerance - 32'd1 - 32'($urandom_range(0, 100000));
    endfunction

    initial begin
        int unsigned t;
        int unsigned r;
        aresetn       = 1'b0;
        cfg_nominal   = 32'd125000000;
        cfg_tolerance = 32'd1000;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        model_reset();
        repeat (3) step();
        do_reset("init");
        check_all("after reset");

        // Eight identical good periods -> single output pulse with exact sum
        for (int i = 0; i < 7; i++) send_check(32'd125000500, "nominal block");
        send(32'd125000500);
        step();
        check_all("nominal done");
        chk("nominal sum", m_axis_tdata, 64'd1000004000);
        chk("nominal locked", {63'd0, sts_locked}, 64'd1);
        step();
        exp_valid = 1'b0;
        chk("nominal pulse end", {63'd0, m_axis_tvalid}, 64'd0);

        // HUNT: a bad sample discards the partial block
        do_reset("hunt");
        for (int i = 0; i < 5; i++) send_check(rnd_good(), "hunt pre");
        send_check(32'd124990000, "hunt bad");
        for (int i = 0; i < 8; i++) send_check(rnd_good(), "hunt post");

        // LOCKED: single bad tolerated, second consecutive bad unlocks
        do_reset("lockbad");
        for (int i = 0; i < 8; i++) send_check(rnd_good(), "lock fill");
        send_check(32'd126000000, "lock one bad");
        for (int i = 0; i < 3; i++) send_check(rnd_good(), "lock recover");
        send_check(rnd_bad(), "lock bad 1");
        send_check(rnd_bad(), "lock bad 2");

        // Stalled sink across two completions -> overwrite and overrun
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) send_check(rnd_good(), "stall");
        m_axis_tready = 1'b1;
        step();
        exp_valid = 1'b0;
        check_all("stall drain");

        // Reset mid-block, with output pending and with a sample in flight
        m_axis_tready = 1'b0;
        for (int i = 0; i < 11; i++) send_check(rnd_good(), "pre reset");
        do_reset("mid block");
        m_axis_tready = 1'b1;
        send(rnd_good());
        do_reset("in flight");
        for (int i = 0; i < 8; i++) send_check(rnd_good(), "post reset");

        // Watchdog boundary with a scaled period (limit 1010)
        cfg_nominal   = 32'd1000;
        cfg_tolerance = 32'd10;
        do_reset("watchdog");
        for (int i = 0; i < 8; i++) send_check(rnd_good(), "wd fill");
        t = m_last + 32'd1011;
        wait_until(t - 1);
        send_check(rnd_good(), "wd expiry sample");
        t = m_last + 32'd1011;
        wait_until(t);
        check_all("wd last cycle");
        step();
        check_all("wd timed out");
        chk("wd unlocked", {63'd0, sts_locked}, 64'd0);

        // Random mix plus window edges at nominal 125 MHz
        cfg_nominal   = 32'd125000000;
        cfg_tolerance = 32'd1000;
        do_reset("random");
        send_check(32'd125001000, "edge hi good");
        send_check(32'd124999000, "edge lo good");
        send_check(32'd125001001, "edge hi bad");
        send_check(32'd124998999, "edge lo bad");
        for (int i = 0; i < 48; i++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      send_check(rnd_good(), "rand good");
            else if (r < 95) send_check(rnd_bad(), "rand bad");
            else if (r < 98) send_check(32'd0, "rand zero");
            else             send_check(32'hFFFFFFFF, "rand max");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_pps_filter.md
AXIS_PPS_FILTER -- requirements
Module: axis_pps_filter

Interface
REQ-001 SHALL have parameter CNTR_WIDTH, default 32: width of input period samples.
REQ-002 SHALL have parameter AVG_LOG2, default 3: block length 2^AVG_LOG2 accepted periods.
REQ-003 SHALL have parameter M_AXIS_TDATA_WIDTH, default 64: output width, at least CNTR_WIDTH+AVG_LOG2.
REQ-004 SHALL have ports: aclk  in  1  single clock; aresetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: cfg_nominal  in  CNTR_WIDTH  expected clocks per PPS period; cfg_tolerance  in  CNTR_WIDTH  allowed deviation.
REQ-006 SHALL have ports: s_axis_tdata  in  CNTR_WIDTH  period count from the PPS counter stage; s_axis_tvalid  in  1  one-cycle sample strobe; s_axis_tready  out  1  constant 1.
REQ-007 SHALL have ports: m_axis_tdata  out  M_AXIS_TDATA_WIDTH  block sum, zero-extended; m_axis_tvalid  out  1; m_axis_tready  in  1.
REQ-008 SHALL have ports: sts_locked  out  1; sts_overrun  out  1  sticky; sts_reject_cnt  out  16  rejected-sample count.

Function
REQ-009 SHALL accept a sample as good when |s_axis_tdata - cfg_nominal| <= cfg_tolerance, computed at CNTR_WIDTH+1 bits with no wrap; equality is good.
REQ-010 SHALL implement states HUNT and LOCKED; HUNT after reset.
REQ-011 SHALL, in either state, add each good sample to a (CNTR_WIDTH+AVG_LOG2)-bit accumulator and increment a block counter.
REQ-012 SHALL, when the 2^AVG_LOG2-th good sample of a block is added, load the sum into the output register, clear the accumulator and block counter, and move HUNT->LOCKED.
REQ-013 SHALL assert m_axis_tvalid 2 cycles after the s_axis_tvalid cycle of the completing sample (stage 1: register sample and check; stage 2: accumulate and output).
REQ-014 SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0, and deassert m_axis_tvalid the cycle after a handshake.
REQ-015 SHALL, if a new block completes while m_axis_tvalid=1 and m_axis_tready=0, overwrite m_axis_tdata with the new sum, keep m_axis_tvalid=1, and set sts_overrun.
REQ-016 SHALL treat handshake and new block completion in the same cycle as a normal transfer followed by the new sum being valid, without setting sts_overrun.
REQ-017 SHALL, on a bad sample in HUNT, discard it and clear the accumulator and block counter.
REQ-018 SHALL, on a bad sample in LOCKED, discard it without clearing the block.
REQ-019 SHALL, on a second consecutive bad sample in LOCKED, go to HUNT and clear the block; any good sample clears the consecutive-bad count.
REQ-020 SHALL run a watchdog counting cycles since the last s_axis_tvalid, armed only after the first sample following reset.
REQ-021 SHALL, when the watchdog exceeds cfg_nominal+cfg_tolerance (CNTR_WIDTH+1 bits), go to HUNT, clear the block, and disarm until the next sample.
REQ-022 SHALL restart the watchdog on any sample, good or bad; a sample on the expiry cycle wins and no timeout occurs.
REQ-023 SHALL drive sts_locked=1 exactly in LOCKED.
REQ-024 SHALL use cfg_* values sampled in the cycle of each check, with no retiming.

Reset
REQ-025 SHALL, on aresetn=0, asynchronously clear all state: HUNT, accumulator, block counter, watchdog disarmed, m_axis_tvalid=0, m_axis_tdata=0, sts_locked=0, sts_overrun=0, sts_reject_cnt=0.
REQ-026 SHALL discard any in-flight pipeline sample and pending output on reset mid-block.

Configuration
REQ-027 SHALL, with PPS_FILTER_STATS_EN defined, count every rejected sample in sts_reject_cnt, saturating at 65535.
REQ-028 SHALL, without PPS_FILTER_STATS_EN, tie sts_reject_cnt to 0, keep the port, and implement no counter logic.

Structure
REQ-029 SHALL place the HUNT/LOCKED state encodings and the consecutive-bad limit of 2 in shared package pps_pkg.
REQ-030 SHALL implement the REQ-009 check in sub-module axis_pps_window_check (combinational compare, registered good flag).

Verification
REQ-031 SHALL cover: nominal 125000000, tolerance 1000, AVG_LOG2=3, eight samples of 125000500 with m_axis_tready=1 -> m_axis_tvalid for one cycle, m_axis_tdata=1000004000, sts_locked=1 two cycles after the 8th sample.
REQ-032 SHALL cover: in HUNT, five good samples then 124990000 then eight good samples -> one output, from the last eight only.
REQ-033 SHALL cover: LOCKED, one sample of 126000000 then good samples -> sts_locked stays 1, sts_reject_cnt=1 (STATS_EN); two consecutive bad samples -> sts_locked=0.
REQ-034 SHALL cover: LOCKED with no sample for 125001001 cycles -> sts_locked=0; a sample arriving exactly on the expiry cycle -> sts_locked stays 1.
REQ-035 SHALL cover: m_axis_tready=0 across two block completions -> m_axis_tdata equals the second sum, sts_overrun=1.
REQ-036 SHALL cover: aresetn pulsed low mid-block and while m_axis_tvalid=1 -> all outputs 0 immediately; the next output requires eight new good samples.
